// File: rtl/sd_recode_pkg.sv
// Shared types and constants for the radix-10 signed-digit recoding sequencer.
package sd_recode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // One-hot magnitude encoding {y5,y4,y3,y2,y1}; all zero means digit 0
  localparam logic [4:0] MAG_0 = 5'b00000;
  localparam logic [4:0] MAG_1 = 5'b00001;
  localparam logic [4:0] MAG_2 = 5'b00010;
  localparam logic [4:0] MAG_3 = 5'b00100;
  localparam logic [4:0] MAG_4 = 5'b01000;
  localparam logic [4:0] MAG_5 = 5'b10000;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] SD_THRESH = 4'd5;

  // Binary magnitude 0..5 to one-hot; anything larger maps to zero
  function automatic logic [4:0] mag_onehot(input logic [3:0] m);
    logic [4:0] r;
    case (m)
      4'd1:    r = MAG_1;
      4'd2:    r = MAG_2;
      4'd3:    r = MAG_3;
      4'd4:    r = MAG_4;
      4'd5:    r = MAG_5;
      default: r = MAG_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sd_digit_recode.sv
// Single BCD digit to signed-digit recoder: value = y + t - 10*(y>=5).
// With BCD_CHECK_EN defined, digits above 9 flag err, recode to 0 and
// suppress the outgoing transfer.
module sd_digit_recode
  import sd_recode_pkg::*;
(
  input  logic [3:0] y,
  input  logic       t,
  output logic [4:0] mag,
  output logic       neg,
  output logic       ys,
  output logic       err
);

  logic       ge5;
  logic       bad;
  logic [3:0] mag_val;

  // Recode one digit into sign plus one-hot magnitude
  always_comb begin
    ge5     = (y >= SD_THRESH);
`ifdef BCD_CHECK_EN
    bad     = (y > BCD_MAX);
`else
    bad     = 1'b0;
`endif
    neg     = 1'b0;
    mag_val = 4'd0;
    if (bad) begin
      mag_val = 4'd0;
    end else if (ge5) begin
      // y+t-10 lies in -5..0, so magnitude is 10-y-t
      mag_val = 4'd10 - y - {3'b000, t};
      neg     = (mag_val != 4'd0);
    end else begin
      mag_val = y + {3'b000, t};
    end
    mag = mag_onehot(mag_val);
    ys  = ge5 && !bad;
    err = bad;
  end

endmodule

// File: rtl/sd_recode_sequencer.sv
// Serial radix-10 SD recoding controller: accepts an NDIG-digit BCD operand,
// emits NDIG recoded digits LSB first, then one transfer digit.
// Optional BCD_CHECK_EN enables invalid-digit flagging in the recoder.
module sd_recode_sequencer
  import sd_recode_pkg::*;
#(
  parameter int unsigned NDIG = 16,
  parameter int unsigned IDXW = $clog2(NDIG + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*NDIG-1:0]   in_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_mag,
  output logic                out_neg,
  output logic [IDXW-1:0]     out_idx,
  output logic                out_last,
  output logic                out_err
);

  localparam int unsigned OPW = 4 * NDIG;

  state_t         state;
  logic [OPW-1:0] sreg;      // digits not yet presented, next one at [3:0]
  logic           transfer;  // transfer into the digit held at sreg[3:0]

  logic [3:0] rec_y;
  logic       rec_t;
  logic [4:0] rec_mag;
  logic       rec_neg;
  logic       rec_ys;
  logic       rec_err;

  // Recoder looks ahead: incoming LSB digit in IDLE, next queued digit otherwise
  always_comb begin
    rec_y = sreg[3:0];
    rec_t = transfer;
    if (state == IDLE) begin
      rec_y = in_bcd[3:0];
      rec_t = 1'b0;
    end
  end

  sd_digit_recode u_rec (
    .y   (rec_y),
    .t   (rec_t),
    .mag (rec_mag),
    .neg (rec_neg),
    .ys  (rec_ys),
    .err (rec_err)
  );

  // Sequencer FSM with registered outputs held during backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      transfer  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_mag   <= MAG_0;
      out_neg   <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg      <= in_bcd >> 4;
            transfer  <= rec_ys;
            out_mag   <= rec_mag;
            out_neg   <= rec_neg;
            out_err   <= rec_err;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (out_idx == IDXW'(NDIG - 1)) begin
              out_mag  <= transfer ? MAG_1 : MAG_0;
              out_neg  <= 1'b0;
              out_err  <= 1'b0;
              out_last <= 1'b1;
              out_idx  <= IDXW'(NDIG);
              state    <= FLUSH;
            end else begin
              sreg     <= sreg >> 4;
              transfer <= rec_ys;
              out_mag  <= rec_mag;
              out_neg  <= rec_neg;
              out_err  <= rec_err;
              out_idx  <= out_idx + IDXW'(1);
            end
          end
        end
        FLUSH: begin
          if (out_ready) begin
            sreg      <= '0;
            transfer  <= 1'b0;
            out_valid <= 1'b0;
            out_mag   <= MAG_0;
            out_neg   <= 1'b0;
            out_err   <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
